// File: rtl/synchronous_fifo_ring.sv
// Single-clock circular-buffer FIFO. Depth can be any integer >= 2 and every
// entry is usable. The head word falls through, and an occupancy count is provided.
module synchronous_fifo_ring #(
    parameter int DEPTH        = 8,
    parameter int DATA_WIDTH   = 8,
    parameter int AFULL_LEVEL  = DEPTH - 1,
    parameter int AEMPTY_LEVEL = 1,
    parameter int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  poll,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] head,
    output logic [DATA_WIDTH-1:0] tail,
    output logic [CNT_W-1:0]      count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wp;
    logic [PTR_W-1:0]      rp;
    logic                  push_ok;
    logic                  pop_ok;
    logic [CNT_W-1:0]      count_next;
    logic [PTR_W-1:0]      wp_inc;
    logic [PTR_W-1:0]      rp_inc;

    // A push is accepted when the FIFO has room, or when a pop in the same
    // cycle frees a slot. A poll is accepted only when the FIFO holds data.
    // Both decisions use registered state only, so no output depends
    // combinationally on push or poll.
    always_comb begin
        pop_ok     = poll && !empty;
        push_ok    = push && (!full || poll);
        count_next = count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        wp_inc     = (wp == LAST_IDX) ? '0 : wp + 1'b1;
        rp_inc     = (rp == LAST_IDX) ? '0 : rp + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wp] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp           <= '0;
            rp           <= '0;
            count        <= '0;
            tail         <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else if (flush) begin
            wp           <= '0;
            rp           <= '0;
            count        <= '0;
            tail         <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (push_ok) begin
                wp   <= wp_inc;
                tail <= data_in;
            end
            if (pop_ok) begin
                rp <= rp_inc;
            end
            count        <= count_next;
            full         <= (count_next == CNT_W'(DEPTH));
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= CNT_W'(AFULL_LEVEL));
            almost_empty <= (count_next <= CNT_W'(AEMPTY_LEVEL));
            if (push && full && !poll) begin
                overflow <= 1'b1;
            end
            if (poll && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    // The newest word is written at mem[wp] while rp still points at it, so a
    // word pushed into an empty FIFO appears on head on the same edge.
    assign head = empty ? '0 : mem[rp];

endmodule

// File: tb/tb_synchronous_fifo_ring.sv
// Directed bench for synchronous_fifo_ring with DEPTH=5, AFULL_LEVEL=4 and AEMPTY_LEVEL=1.
// It covers fill, push while full, wrap, underflow, flush and asynchronous reset.
module tb_synchronous_fifo_ring;

    localparam int DEPTH = 5;
    localparam int DW    = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst_n;
    logic          push;
    logic          poll;
    logic          flush;
    logic [DW-1:0] data_in;
    logic [DW-1:0] head;
    logic [DW-1:0] tail;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic          overflow;
    logic          underflow;

    int total;
    int bad;

    synchronous_fifo_ring #(
        .DEPTH(DEPTH),
        .DATA_WIDTH(DW),
        .AFULL_LEVEL(4),
        .AEMPTY_LEVEL(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .push(push),
        .poll(poll),
        .flush(flush),
        .data_in(data_in),
        .head(head),
        .tail(tail),
        .count(count),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .overflow(overflow),
        .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of stimulus and return #1 after the edge.
    task automatic step(input logic p, input logic q, input logic f, input logic [DW-1:0] d);
        push    = p;
        poll    = q;
        flush   = f;
        data_in = d;
        @(posedge clk);
        #1;
        push    = 1'b0;
        poll    = 1'b0;
        flush   = 1'b0;
        data_in = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        push = 1'b0; poll = 1'b0; flush = 1'b0; data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, '0);
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got %0d want 0", count); end
        total++; if (empty !== 1'b1 || almost_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got %b/%b want 1/1", empty, almost_empty); end
        total++; if (full !== 1'b0 || almost_full !== 1'b0) begin bad++; $display("FAIL reset_full got %b/%b want 0/0", full, almost_full); end
        total++; if (head !== 8'h00 || tail !== 8'h00) begin bad++; $display("FAIL reset_data got %h/%h want 00/00", head, tail); end
        total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin bad++; $display("FAIL reset_err got %b/%b want 0/0", overflow, underflow); end
    endtask

    task automatic test_fill();
        logic [DW-1:0] vals [5];
        logic          exp_ae [5];
        logic          exp_af [5];
        logic          exp_fu [5];
        vals   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        exp_ae = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_af = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_fu = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, vals[i]);
            total++; if (count !== CW'(i + 1)) begin bad++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i + 1); end
            total++; if (almost_empty !== exp_ae[i] || almost_full !== exp_af[i] || full !== exp_fu[i] || empty !== 1'b0) begin
                bad++; $display("FAIL fill_flags[%0d] got ae=%b af=%b f=%b e=%b want ae=%b af=%b f=%b e=0",
                                i, almost_empty, almost_full, full, empty, exp_ae[i], exp_af[i], exp_fu[i]);
            end
            total++; if (head !== 8'h11 || tail !== vals[i]) begin bad++; $display("FAIL fill_data[%0d] got %h/%h want 11/%h", i, head, tail, vals[i]); end
        end
    endtask

    task automatic test_full_push_poll();
        step(1'b1, 1'b1, 1'b0, 8'h66);
        total++; if (count !== 3'd5 || full !== 1'b1) begin bad++; $display("FAIL fullpp_count got %0d/%b want 5/1", count, full); end
        total++; if (head !== 8'h22 || tail !== 8'h66) begin bad++; $display("FAIL fullpp_data got %h/%h want 22/66", head, tail); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fullpp_ovf got %b want 0", overflow); end
        step(1'b1, 1'b0, 1'b0, 8'h77);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL overflow_set got %b want 1", overflow); end
        total++; if (tail !== 8'h66 || count !== 3'd5 || head !== 8'h22) begin bad++; $display("FAIL overflow_reject got tail=%h cnt=%0d head=%h want 66/5/22", tail, count, head); end
    endtask

    task automatic test_drain();
        logic [DW-1:0] exp_h [5];
        exp_h = '{8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        for (int i = 0; i < 5; i++) begin
            total++; if (head !== exp_h[i]) begin bad++; $display("FAIL drain_head[%0d] got %h want %h", i, head, exp_h[i]); end
            step(1'b0, 1'b1, 1'b0, '0);
            total++; if (count !== CW'(4 - i)) begin bad++; $display("FAIL drain_count[%0d] got %0d want %0d", i, count, 4 - i); end
        end
        total++; if (empty !== 1'b1 || head !== 8'h00 || underflow !== 1'b0) begin bad++; $display("FAIL drain_end got e=%b head=%h uf=%b want 1/00/0", empty, head, underflow); end
        step(1'b0, 1'b1, 1'b0, '0);
        total++; if (underflow !== 1'b1 || count !== 3'd0 || overflow !== 1'b1) begin bad++; $display("FAIL underflow_set got uf=%b cnt=%0d ovf=%b want 1/0/1", underflow, count, overflow); end
    endtask

    task automatic test_empty_push_poll();
        step(1'b0, 1'b0, 1'b1, '0);
        total++; if (underflow !== 1'b0 || overflow !== 1'b0) begin bad++; $display("FAIL flush_err_clear got %b/%b want 0/0", overflow, underflow); end
        step(1'b1, 1'b1, 1'b0, 8'hA5);
        total++; if (count !== 3'd1 || head !== 8'hA5 || tail !== 8'hA5) begin bad++; $display("FAIL emptypp got cnt=%0d head=%h tail=%h want 1/a5/a5", count, head, tail); end
        total++; if (underflow !== 1'b1 || empty !== 1'b0) begin bad++; $display("FAIL emptypp_uf got uf=%b e=%b want 1/0", underflow, empty); end
    endtask

    task automatic test_flush();
        step(1'b0, 1'b0, 1'b1, '0);
        step(1'b1, 1'b0, 1'b0, 8'hB1);
        step(1'b1, 1'b0, 1'b0, 8'hB2);
        step(1'b1, 1'b0, 1'b0, 8'hB3);
        total++; if (count !== 3'd3 || head !== 8'hB1 || tail !== 8'hB3) begin bad++; $display("FAIL flush_load got cnt=%0d head=%h tail=%h want 3/b1/b3", count, head, tail); end
        step(1'b1, 1'b0, 1'b1, 8'hC4);
        total++; if (count !== 3'd0 || empty !== 1'b1 || almost_empty !== 1'b1) begin bad++; $display("FAIL flush_count got cnt=%0d e=%b ae=%b want 0/1/1", count, empty, almost_empty); end
        total++; if (head !== 8'h00 || tail !== 8'h00 || overflow !== 1'b0 || underflow !== 1'b0) begin
            bad++; $display("FAIL flush_state got head=%h tail=%h ovf=%b uf=%b want 00/00/0/0", head, tail, overflow, underflow);
        end
        step(1'b0, 1'b0, 1'b0, '0);
        total++; if (count !== 3'd0 || empty !== 1'b1) begin bad++; $display("FAIL flush_discard got cnt=%0d e=%b want 0/1", count, empty); end
    endtask

    task automatic test_async_reset();
        step(1'b1, 1'b0, 1'b0, 8'hD1);
        step(1'b1, 1'b0, 1'b0, 8'hD2);
        total++; if (count !== 3'd2 || head !== 8'hD1) begin bad++; $display("FAIL arst_load got cnt=%0d head=%h want 2/d1", count, head); end
        #1;
        rst_n = 1'b0;
        #1;
        total++; if (count !== 3'd0 || empty !== 1'b1 || almost_empty !== 1'b1) begin bad++; $display("FAIL arst_count got cnt=%0d e=%b ae=%b want 0/1/1", count, empty, almost_empty); end
        total++; if (head !== 8'h00 || tail !== 8'h00 || full !== 1'b0 || almost_full !== 1'b0) begin
            bad++; $display("FAIL arst_state got head=%h tail=%h f=%b af=%b want 00/00/0/0", head, tail, full, almost_full);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 8'hE7);
        total++; if (count !== 3'd1 || head !== 8'hE7 || tail !== 8'hE7) begin bad++; $display("FAIL arst_resume got cnt=%0d head=%h tail=%h want 1/e7/e7", count, head, tail); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_fill();
        test_full_push_poll();
        test_drain();
        test_empty_push_poll();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
